// File: rtl/mrelbp_win5_line_buffer.sv
// mrelbp_win5_line_buffer: four-line buffer presenting a vertical 5-pixel column per accepted raster pixel.
module mrelbp_win5_line_buffer #(
  parameter int COLS = 7,
  parameter int ROWS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic [7:0] S3,
  output logic [7:0] S4,
  output logic [7:0] S5,
  output logic       done_o,
  output logic [9:0] col_o,
  output logic [9:0] row_o,
  output logic       frame_done_o
);
  localparam int IW = COLS > 1 ? $clog2(COLS) : 1;
  logic [7:0] l0 [COLS];
  logic [7:0] l1 [COLS];
  logic [7:0] l2 [COLS];
  logic [7:0] l3 [COLS];
  logic [9:0] col_cnt, row_cnt;
  logic [IW-1:0] c;
  logic last_col, last_row;
  assign c = col_cnt[IW-1:0];
  assign last_col = col_cnt == 10'(COLS - 1);
  assign last_row = row_cnt == 10'(ROWS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {S1, S2, S3, S4, S5} <= '0;
      col_o <= '0;
      row_o <= '0;
      done_o <= 1'b0;
      frame_done_o <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      done_o <= valid_i && row_cnt >= 10'd4;
      frame_done_o <= valid_i && last_col && last_row;
      if (valid_i) begin
        S1 <= l0[c];
        S2 <= l1[c];
        S3 <= l2[c];
        S4 <= l3[c];
        S5 <= data_i;
        col_o <= col_cnt;
        row_o <= row_cnt;
        col_cnt <= last_col ? '0 : col_cnt + 10'd1;
        row_cnt <= !last_col ? row_cnt : last_row ? '0 : row_cnt + 10'd1;
      end
    end
  end
  // Line memories are never cleared; done_o gating keeps stale rows hidden.
  always_ff @(posedge clk) begin
    if (rst_n && valid_i) begin
      l0[c] <= l1[c];
      l1[c] <= l2[c];
      l2[c] <= l3[c];
      l3[c] <= data_i;
    end
  end
endmodule

// File: tb/tb_mrelbp_win5_line_buffer.sv
// tb_mrelbp_win5_line_buffer: directed checks of the 5-row column buffer for 7x7 and 16x5 frames.
module tb_mrelbp_win5_line_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, valid_i;
  logic [7:0] data_i;
  logic [7:0] s1, s2, s3, s4, s5;
  logic done_o, frame_done_o;
  logic [9:0] col_o, row_o;
  logic rst_nb, valid_b;
  logic [7:0] data_b;
  logic [7:0] b1, b2, b3, b4, b5;
  logic done_b, fd_b;
  logic [9:0] col_b, row_b;
  int compared = 0;
  int mismatched = 0;
  int last_c = 0;

  mrelbp_win5_line_buffer #(.COLS(7), .ROWS(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .S1(s1), .S2(s2), .S3(s3), .S4(s4), .S5(s5),
    .done_o(done_o), .col_o(col_o), .row_o(row_o), .frame_done_o(frame_done_o)
  );

  mrelbp_win5_line_buffer #(.COLS(16), .ROWS(5)) dut_b (
    .clk(clk), .rst_n(rst_nb), .valid_i(valid_b), .data_i(data_b),
    .S1(b1), .S2(b2), .S3(b3), .S4(b4), .S5(b5),
    .done_o(done_b), .col_o(col_b), .row_o(row_b), .frame_done_o(fd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_i = v;
    data_i = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + 10 * r + c);
  endfunction

  task automatic check_reset_outputs();
    check("rst_s1", s1, 0);
    check("rst_s2", s2, 0);
    check("rst_s3", s3, 0);
    check("rst_s4", s4, 0);
    check("rst_s5", s5, 0);
    check("rst_col", col_o, 0);
    check("rst_row", row_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fd", frame_done_o, 0);
  endtask

  task automatic run_frame(input int base, input bit gaps);
    int nd = 0;
    int nf = 0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) begin
        while (gaps && $urandom_range(0, 99) < 40) begin
          step(1'b0, 8'h55);
          check("idle_done", done_o, 0);
          check("idle_fd", frame_done_o, 0);
          check("idle_col_hold", col_o, last_c);
        end
        step(1'b1, pix(base, r, c));
        last_c = c;
        check("col", col_o, c);
        check("row", row_o, r);
        check("s5", s5, pix(base, r, c));
        check("done", done_o, {31'd0, r >= 4});
        check("frame_done", frame_done_o, {31'd0, r == 6 && c == 6});
        if (r >= 4) begin
          check("s1", s1, pix(base, r - 4, c));
          check("s2", s2, pix(base, r - 3, c));
          check("s3", s3, pix(base, r - 2, c));
          check("s4", s4, pix(base, r - 1, c));
        end
        nd += int'(done_o);
        nf += int'(frame_done_o);
      end
    end
    check("done_count", nd, 21);
    check("frame_done_count", nf, 1);
  endtask

  initial begin
    int nd;
    int nf;
    rst_n = 1'b0;
    rst_nb = 1'b0;
    valid_b = 1'b0;
    data_b = 8'h00;
    step(1'b1, 8'hFF);
    check_reset_outputs();
    rst_nb = 1'b1;
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    check("post_rst_done", done_o, 0);

    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    run_frame(200, 1'b0);

    // Partial frame then reset coinciding with a valid 0xFF pixel.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pix(0, i / 7, i % 7));
      check("partial_done", done_o, 0);
    end
    rst_n = 1'b0;
    step(1'b1, 8'hFF);
    check_reset_outputs();
    rst_n = 1'b1;
    last_c = 0;
    run_frame(200, 1'b0);

    nd = 0;
    nf = 0;
    valid_i = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 16; c++) begin
        valid_b = 1'b1;
        data_b = 8'(16 * r + c);
        @(posedge clk);
        #1;
        check("b_done", done_b, {31'd0, r == 4});
        check("b_fd", fd_b, {31'd0, r == 4 && c == 15});
        check("b_s5", b5, 16 * r + c);
        if (r == 4) begin
          check("b_col", col_b, c);
          check("b_row", row_b, 4);
          check("b_s1", b1, c);
          check("b_s2", b2, 16 + c);
          check("b_s3", b3, 32 + c);
          check("b_s4", b4, 48 + c);
        end
        nd += int'(done_b);
        nf += int'(fd_b);
      end
    end
    valid_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_idle_done", done_b, 0);
    check("b_done_count", nd, 16);
    check("b_fd_count", nf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
